// File: rtl/secuenciador_calculo.sv
// Sequencer between the operand switches and a shared multicycle arithmetic unit:
// captures operands on a debounced go, pulses start, waits for done under a watchdog.
module secuenciador_calculo #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   binA,
    input  logic [WIDTH-1:0]   binB,
    input  logic [1:0]         op,
    input  logic               btn_go,
    input  logic               btn_clr,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [1:0]         alu_op,
    output logic               alu_start,
    input  logic               alu_done,
    input  logic [2*WIDTH-1:0] alu_result,
    output logic [2*WIDTH-1:0] result,
    output logic               result_valid,
    output logic               busy,
    output logic               error
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_SHOW,
        S_ERR
    } state_t;

    state_t             r_state;
    logic [2:0]         r_go_sync;
    logic [2:0]         r_clr_sync;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [1:0]         r_alu_op;
    logic               r_alu_start;
    logic [2*WIDTH-1:0] r_result;
    logic               r_result_valid;
    logic               r_busy;
    logic               r_error;
    logic               w_go_p;
    logic               w_clr_p;

    // Two synchronizer stages plus one delay stage; pulse on the rising edge only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_go_sync  <= '0;
            r_clr_sync <= '0;
        end else begin
            r_go_sync  <= {r_go_sync[1:0], btn_go};
            r_clr_sync <= {r_clr_sync[1:0], btn_clr};
        end
    end

    assign w_go_p  = r_go_sync[1] & ~r_go_sync[2];
    assign w_clr_p = r_clr_sync[1] & ~r_clr_sync[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_op       <= '0;
            r_alu_start    <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            // Clear has priority over everything, including a simultaneous go.
            if (w_clr_p) begin
                r_state        <= S_IDLE;
                r_cnt          <= '0;
                r_result       <= '0;
                r_result_valid <= 1'b0;
                r_busy         <= 1'b0;
                r_error        <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_go_p) begin
                            r_state <= S_LOAD;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        r_alu_a        <= binA;
                        r_alu_b        <= binB;
                        r_alu_op       <= op;
                        r_result_valid <= 1'b0;
                        r_alu_start    <= 1'b1;
                        r_state        <= S_START;
                    end
                    S_START: begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        // A done on the last allowed cycle still beats the watchdog.
                        if (alu_done) begin
                            r_result       <= alu_result;
                            r_result_valid <= 1'b1;
                            r_busy         <= 1'b0;
                            r_state        <= S_SHOW;
                        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_ERR;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_SHOW: begin
                        if (w_go_p) begin
                            r_state <= S_LOAD;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_ERR: begin
                        r_state <= S_ERR;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign alu_start    = r_alu_start;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign error        = r_error;

endmodule

// File: tb/tb_secuenciador_calculo.sv
// Randomized bench for secuenciador_calculo: a transaction-level model predicts
// capture values, start/result/error latencies and button behaviour.
module tb_secuenciador_calculo;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [WIDTH-1:0]   binA = '0;
    logic [WIDTH-1:0]   binB = '0;
    logic [1:0]         op = '0;
    logic               btn_go = 1'b0;
    logic               btn_clr = 1'b0;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [1:0]         alu_op;
    logic               alu_start;
    logic               alu_done = 1'b0;
    logic [2*WIDTH-1:0] alu_result = '0;
    logic [2*WIDTH-1:0] result;
    logic               result_valid;
    logic               busy;
    logic               error;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2*WIDTH-1:0] prev_result = '0;

    secuenciador_calculo #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .binA(binA), .binB(binB), .op(op),
        .btn_go(btn_go), .btn_clr(btn_clr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result),
        .result(result), .result_valid(result_valid), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic unit behaviour.
    function automatic logic [15:0] unit_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
        case (o)
            2'd0:    return {8'h00, a} + {8'h00, b};
            2'd1:    return {8'h00, a} - {8'h00, b};
            2'd2:    return {8'h00, a} * {8'h00, b};
            default: return {a, b};
        endcase
    endfunction

    task automatic press_clr();
        btn_clr = 1'b1;
        tick(); tick();
        btn_clr = 1'b0;
        repeat (4) tick();
        prev_result = '0;
    endtask

    // One calculation: lat = WAIT cycle in which the unit answers (> TIMEOUT means too late).
    task automatic run_calc(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o,
                            input int lat, input int hold, input bit chg_a);
        int n_start, t_start, t_valid, t_err, c, n_ign;
        logic [15:0] exp_res;
        exp_res = unit_fn(a, b, o);
        $display("calc a=%02h b=%02h op=%0d lat=%0d hold=%0d exp=%04h", a, b, o, lat, hold, exp_res);
        binA = a; binB = b; op = o; btn_go = 1'b1;
        n_start = 0; t_start = -1; t_valid = -1; t_err = -1;
        for (int t = 1; t <= hold + 20; t++) begin
            tick();
            if (t == hold) btn_go = 1'b0;
            alu_done   = 1'b0;
            alu_result = 16'($urandom);
            if (alu_start) begin
                n_start++;
                if (t_start < 0) begin
                    t_start = t;
                    chk("cap_a", alu_a, a);
                    chk("cap_b", alu_b, b);
                    chk("cap_op", alu_op, o);
                    chk("valid_dropped", result_valid, 0);
                    chk("old_result_held", result, prev_result);
                    chk("busy_start", busy, 1);
                    if (chg_a) binA = 8'h0F;
                end
            end
            if (t_start > 0) begin
                c = t - t_start;
                if (t_valid < 0 && result_valid) t_valid = c;
                if (t_err < 0 && error) t_err = c;
                if (c == lat) begin
                    alu_done   = 1'b1;
                    alu_result = unit_fn(alu_a, alu_b, alu_op);
                end
            end
        end
        alu_done = 1'b0;
        chk("start_count", n_start, 1);
        chk("start_latency", t_start, 4);
        chk("alu_a_stable", alu_a, a);
        chk("busy_end", busy, 0);
        if (lat <= TIMEOUT) begin
            chk("valid_latency", t_valid, lat + 1);
            chk("result", result, exp_res);
            chk("result_valid", result_valid, 1);
            chk("no_error", error, 0);
            prev_result = exp_res;
        end else begin
            chk("error_latency", t_err, TIMEOUT + 1);
            chk("valid_after_timeout", result_valid, 0);
            chk("result_after_timeout", result, prev_result);
            btn_go = 1'b1;
            n_ign = 0;
            for (int t = 0; t < 10; t++) begin
                tick();
                if (t == 2) btn_go = 1'b0;
                if (alu_start) n_ign++;
            end
            chk("go_ignored_in_err", n_ign, 0);
            chk("error_held", error, 1);
            press_clr();
            chk("clr_error", error, 0);
            chk("clr_busy", busy, 0);
            chk("clr_result", result, 0);
        end
    endtask

    initial begin
        int n_st;
        // Reset state
        repeat (3) tick();
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_result", result, 0);
        chk("rst_valid_busy_err", {result_valid, busy, error}, 0);
        rst = 1'b0;
        repeat (3) tick();

        // Normal op with operand change during WAIT, then re-trigger from SHOW
        run_calc(8'h55, 8'hF0, 2'd2, 3, 1, 1'b1);
        run_calc(8'h0F, 8'hF0, 2'd2, 2, 2, 1'b0);
        // Timeout (late answer ignored) and boundary answer on the last WAIT cycle
        run_calc(8'h12, 8'h34, 2'd0, TIMEOUT + 1, 1, 1'b0);
        run_calc(8'hA5, 8'h3C, 2'd1, TIMEOUT, 1, 1'b0);

        // Go and clear rising together from SHOW: clear wins
        btn_go = 1'b1; btn_clr = 1'b1;
        n_st = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (t == 2) begin btn_go = 1'b0; btn_clr = 1'b0; end
            if (alu_start) n_st++;
        end
        prev_result = '0;
        chk("goclr_no_start", n_st, 0);
        chk("goclr_result", result, 0);
        chk("goclr_valid_busy", {result_valid, busy}, 0);

        // Held go for 20 cycles
        run_calc(8'hC3, 8'h07, 2'd3, 2, 20, 1'b0);

        // Random transactions
        for (int i = 0; i < 12; i++)
            run_calc(8'($urandom), 8'($urandom), 2'($urandom), $urandom_range(1, TIMEOUT + 2),
                     $urandom_range(1, 4), 1'($urandom));

        // Reset asserted mid-WAIT, then a stray done
        binA = 8'h99; btn_go = 1'b1;
        tick();
        btn_go = 1'b0;
        for (int i = 0; i < 10 && !alu_start; i++) tick();
        chk("rst_wait_start_seen", alu_start, 1);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_alu_a", alu_a, 0);
        chk("async_rst_outs", {alu_start, result_valid, busy, error}, 0);
        chk("async_rst_result", result, 0);
        tick();
        rst = 1'b0;
        alu_done = 1'b1; alu_result = 16'hFFFF;
        tick();
        alu_done = 1'b0;
        tick();
        chk("stray_done_valid", result_valid, 0);
        chk("stray_done_result", result, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/secuenciador_calculo.md
# secuenciador_calculo

Sequencing controller between the switch-input stage (operands `binA`/`binB`) and the shared multicycle arithmetic unit. A debounced "go" button triggers it to capture the operands and operation code, issue a one-cycle start to the unit, and wait for its done flag. It then latches the result for the display stage. A watchdog flags an error if the unit never answers, and a clear button returns the block to idle from any state.

## Interface
Parameters:
- `WIDTH`, 8: operand width.
- `TIMEOUT`, 255: maximum WAIT cycles before error (≥ 2).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `binA`  in  WIDTH  operand A from input controller.
- `binB`  in  WIDTH  operand B from input controller.
- `op`  in  2  operation select from switches.
- `btn_go`  in  1  raw asynchronous button, start calculation.
- `btn_clr`  in  1  raw asynchronous button, abort/clear.
- `alu_a`, `alu_b`  out  WIDTH  captured operands to arithmetic unit.
- `alu_op`  out  2  captured operation.
- `alu_start`  out  1  one-cycle start pulse.
- `alu_done`  in  1  unit completion flag, sampled only in WAIT.
- `alu_result`  in  2*WIDTH  unit result, valid while `alu_done`=1.
- `result`  out  2*WIDTH  latched result for display.
- `result_valid`  out  1  `result` holds a completed calculation.
- `busy`  out  1  calculation in progress.
- `error`  out  1  watchdog expired.

## Operation
- Both buttons pass through a 2-FF synchronizer plus a delay FF. `go_p` = s2 & ~s3 and `clr_p` likewise give one-cycle pulses on the rising edge only. Holding a button produces no repeat.
- FSM states: IDLE, LOAD, START, WAIT, SHOW, ERR.
- IDLE: `go_p` → LOAD.
- LOAD: capture `binA`→`alu_a`, `binB`→`alu_b`, `op`→`alu_op`. Clear `result_valid`. Go to START unconditionally.
- START: `alu_start`=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- WAIT: if `alu_done`=1, latch `result`←`alu_result`, set `result_valid`=1 and go to SHOW. Otherwise increment the counter. After TIMEOUT consecutive WAIT cycles without done, set `error`=1 and go to ERR.
- SHOW: `result` is held. `go_p` → LOAD (new calculation; the old `result` value stays visible, but `result_valid` drops).
- ERR: `go_p` is ignored. Only `clr_p` exits.
- `clr_p` in any state → IDLE next edge. It clears `result`, `result_valid`, `error` and the counter. `alu_a`/`alu_b`/`alu_op` keep their values.
- `clr_p` and `go_p` in the same cycle: clear wins, and the go is lost.
- `alu_done` outside WAIT (late answer after abort, spurious pulse) is ignored.
- `alu_done` in the same cycle the watchdog would expire: done wins → SHOW, no error.
- `busy`=1 exactly in LOAD, START, WAIT.
- Captured operands are stable from LOAD until the next LOAD. Switch changes during WAIT do not affect the unit.

## Timing
- Reset (asynchronous, immediate): state IDLE; all outputs 0 (`alu_a`, `alu_b`, `alu_op`, `alu_start`, `result`, `result_valid`, `busy`, `error`); synchronizers 0.
- If `btn_go` is first sampled high at edge k:
  - `go_p` is high in the cycle after edge k+1.
  - LOAD follows edge k+2.
  - `alu_start` is high between edges k+3 and k+4.
  - WAIT begins at edge k+4.
- Done sampled at edge d: `result`/`result_valid` update at edge d, so the new value is visible one cycle after done is asserted.
- Minimum go-to-result: a unit answering in the first WAIT cycle gives `result_valid` at edge k+5.
- Watchdog: with no done, `error` rises at the edge ending the TIMEOUT-th WAIT cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset mid-WAIT: assert `rst` asynchronously → all outputs 0 immediately, state IDLE. A later `alu_done` pulse leaves `result_valid`=0.
- Normal op: `binA`=0x55, `binB`=0xF0, `op`=2, press go; model answers 3 cycles after start with 0x4FB0.
  - Expect one `alu_start` pulse, `alu_a`=0x55, `alu_b`=0xF0, `alu_op`=2.
  - Expect `result`=0x4FB0, `result_valid`=1, `busy`=0.
- Operand stability and re-trigger: change `binA` to 0x0F during WAIT → `alu_a` stays 0x55. A second go from SHOW captures 0x0F, drops `result_valid`, and `result` keeps 0x4FB0 until the new done.
- Timeout: `TIMEOUT`=4, model never answers → `error`=1 after the 4th WAIT cycle. go is ignored while in ERR. clr → IDLE with `error`=0.
- Boundary: done arrives exactly on the 4th WAIT cycle → SHOW, `error`=0.
- Simultaneous and held buttons:
  - go and clr rising in the same cycle from SHOW → IDLE, `result`=0.
  - Holding go for 20 cycles → exactly one `alu_start`.
